// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM states, channel widths and frame-length helper for the WS2812 chain driver.
package ws2812_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    localparam int GRB_W = 24;
    localparam int CH_W  = 8;

    function automatic int frame_bits(input int num_leds);
        return GRB_W * num_leds;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: times the HIGH and LOW phase of one bit and flags the last cycle of each phase.
module ws2812_bit_timer #(
    parameter int T0H_CYC = 35,
    parameter int T1H_CYC = 70,
    parameter int BIT_CYC = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic high,
    input  logic bit_val,
    output logic phase_end
);

    localparam int CW = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] T0H_LAST = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] T1H_LAST = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] T0L_LAST = CW'(BIT_CYC - T0H_CYC - 1);
    localparam logic [CW-1:0] T1L_LAST = CW'(BIT_CYC - T1H_CYC - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    always_comb begin
        last      = high ? (bit_val ? T1H_LAST : T0H_LAST) : (bit_val ? T1L_LAST : T0L_LAST);
        phase_end = run && (cnt == last);
    end

    // restarting on phase_end lets the next phase begin counting in the same cycle the FSM switches
    always_ff @(posedge clk) begin
        if (!rst_n || !run || phase_end) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: serialises a masked GRB frame onto a WS2812 chain, then holds the latch gap.
// Define WS2812_BRIGHTNESS_EN to add bright_shift, which right-shifts every channel at the snapshot.
module ws2812_chain_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS  = 5,
    parameter int T0H_CYC   = 35,
    parameter int T1H_CYC   = 70,
    parameter int BIT_CYC   = 125,
    parameter int LATCH_CYC = 6000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [GRB_W*NUM_LEDS-1:0] grb_in,
    input  logic [NUM_LEDS-1:0]       led_en,
    input  logic                      start,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [2:0]                bright_shift,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      dout
);

    localparam int NB = frame_bits(NUM_LEDS);
    localparam int IW = $clog2(NB);
    localparam int LW = $clog2(LATCH_CYC + 1);

    state_t        state;
    logic [NB-1:0] frame;
    logic [NB-1:0] masked;
    logic [IW-1:0] idx;
    logic [LW-1:0] lcnt;
    logic          phase_end;

    // channel c belongs to LED c/3, matching led_en bit order
    always_comb begin
        masked = '0;
        for (int c = 0; c < 3 * NUM_LEDS; c++)
`ifdef WS2812_BRIGHTNESS_EN
            masked[c*CH_W +: CH_W] = (grb_in[c*CH_W +: CH_W] & {CH_W{led_en[c/3]}}) >> bright_shift;
`else
            masked[c*CH_W +: CH_W] = grb_in[c*CH_W +: CH_W] & {CH_W{led_en[c/3]}};
`endif
    end

    ws2812_bit_timer #(
        .T0H_CYC(T0H_CYC),
        .T1H_CYC(T1H_CYC),
        .BIT_CYC(BIT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state == HIGH || state == LOW),
        .high     (state == HIGH),
        .bit_val  (frame[idx]),
        .phase_end(phase_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            frame <= '0;
            idx   <= '0;
            lcnt  <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    frame <= masked;
                    idx   <= IW'(NB - 1);
                    state <= HIGH;
                    dout  <= 1'b1;
                    busy  <= 1'b1;
                end
                HIGH: if (phase_end) begin
                    state <= LOW;
                    dout  <= 1'b0;
                end
                LOW: if (phase_end) begin
                    if (idx == '0) state <= LATCH;
                    else begin
                        idx   <= idx - 1'b1;
                        state <= HIGH;
                        dout  <= 1'b1;
                    end
                end
                LATCH: if (lcnt == LW'(LATCH_CYC - 1)) begin
                    lcnt  <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else lcnt <= lcnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb_ws2812_chain_driver: directed frames; a dout decoder pops expected bits from a scoreboard queue.
module tb_ws2812_chain_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [47:0] grb_in = '0;
    logic [1:0]  led_en = '0;
    logic        busy, done, dout;
`ifdef WS2812_BRIGHTNESS_EN
    logic [2:0]  bright_shift = '0;
`endif

    int vectors = 0;
    int errs = 0;
    bit exp_q[$];
    int hc = 0, lc = 0, last_h = 0;
    bit pd = 1'b0, chk_low = 1'b0;

    ws2812_chain_driver #(
        .NUM_LEDS(2), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .LATCH_CYC(10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .grb_in(grb_in),
        .led_en(led_en),
        .start (start),
`ifdef WS2812_BRIGHTNESS_EN
        .bright_shift(bright_shift),
`endif
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [47:0] g, input logic [1:0] e);
        logic [47:0] m;
        m = g & {{24{e[1]}}, {24{e[0]}}};
`ifdef WS2812_BRIGHTNESS_EN
        for (int c = 0; c < 6; c++) m[c*8 +: 8] = m[c*8 +: 8] >> bright_shift;
`endif
        for (int b = 47; b >= 0; b--) exp_q.push_back(m[b]);
    endtask

    // decode dout: high time gives the bit, low time must complete a 6-cycle bit inside a frame
    always @(negedge clk) begin
        if (!rst_n) begin
            hc = 0; lc = 0; pd = 1'b0; chk_low = 1'b0;
        end else begin
            if (dout && !pd) begin
                if (chk_low) chk("low_time", lc, 6 - last_h);
                hc = 0;
            end
            if (!dout && pd) begin
                last_h = 0;
                if (exp_q.size() != 0) last_h = exp_q.pop_front() ? 4 : 2;
                chk("high_time", hc, last_h);
                lc = 0;
                chk_low = (exp_q.size() % 48) != 0;
            end
            if (dout) hc++; else lc++;
            pd = dout;
        end
    end

    // kind: 0 none, 1 start re-pulse, 2 input change, 3 one-cycle reset (with start) at cycle ev_at
    task automatic run(input logic [47:0] g, input logic [1:0] e, input int ev_at, input int kind,
                       output int blen, output int dn);
        @(posedge clk); #1 grb_in = g; led_en = e; start = 1'b1; push(g, e);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("dout_rise", dout, 1);
        chk("busy_rise", busy, 1);
        blen = 0; dn = 0;
        for (int k = 1; k < 1000 && busy; k++) begin
            blen++; dn += int'(done);
            @(posedge clk); #1;
            if (k == ev_at) begin
                if (kind != 2) start = 1'b1;
                if (kind == 2) begin grb_in = ~g; led_en = ~e; end
                if (kind == 3) rst_n = 1'b0;
            end else if (k == ev_at + 1) begin
                start = 1'b0;
                if (kind == 3) begin rst_n = 1'b1; exp_q.delete(); end
            end
            @(negedge clk);
        end
        dn += int'(done);
    endtask

    task automatic after_frame(input string tag);
        @(negedge clk);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_bits_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int blen, dn;
        logic [47:0] g;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run(48'hFF0000_000001, 2'b11, -1, 0, blen, dn);
        chk("f1_busy_len", blen, 298); chk("f1_done", dn, 1); after_frame("f1");

        run(48'hFFFFFF_FFFFFF, 2'b01, -1, 0, blen, dn);
        chk("f2_busy_len", blen, 298); chk("f2_done", dn, 1); after_frame("f2");

        g = {16'($urandom), $urandom};
        run(g, 2'b11, 50, 1, blen, dn);
        chk("f3_busy_len", blen, 298); chk("f3_done", dn, 1); after_frame("f3");

        g = {16'($urandom), $urandom};
        run(g, 2'b11, 20, 2, blen, dn);
        chk("f4_busy_len", blen, 298); chk("f4_done", dn, 1); after_frame("f4");

        // back-to-back: start held high through done, new data loaded after the first snapshot
        @(posedge clk); #1 grb_in = 48'h123456_ABCDEF; led_en = 2'b11; start = 1'b1;
        push(48'h123456_ABCDEF, 2'b11);
        @(posedge clk); #1 grb_in = 48'h0F0F0F_F0F0F0;
        @(negedge clk);
        for (int k = 0; k < 1000 && !done; k++) @(negedge clk);
        chk("b2b_first_done", done, 1);
        push(48'h0F0F0F_F0F0F0, 2'b11);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_dout", dout, 1);
        chk("b2b_busy", busy, 1);
        blen = 0;
        for (int k = 0; k < 1000 && busy; k++) begin blen++; @(negedge clk); end
        chk("b2b_busy_len", blen, 298); chk("b2b_done", done, 1); after_frame("b2b");

        g = {16'($urandom), $urandom};
        run(g, 2'b11, 100, 3, blen, dn);
        chk("rst_abort_len", blen, 101);
        chk("rst_abort_dout", dout, 0);
        chk("rst_abort_busy", busy, 0);
        for (int k = 0; k < 20; k++) begin dn += int'(done); @(negedge clk); end
        chk("rst_abort_no_done", dn, 0);
        chk("rst_abort_idle", busy, 0);

        g = {16'($urandom), $urandom};
        run(g, 2'b10, -1, 0, blen, dn);
        chk("f6_busy_len", blen, 298); chk("f6_done", dn, 1); after_frame("f6");

`ifdef WS2812_BRIGHTNESS_EN
        @(posedge clk); #1 bright_shift = 3'd3;
        run(48'hFF8010_40FF08, 2'b11, -1, 0, blen, dn);
        chk("br_busy_len", blen, 298); chk("br_done", dn, 1); after_frame("br");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
